baccarat_sm: RTL and testbench
==============================

BACCARAT_SM -- requirements
Module: baccarat_sm

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 step  input  1  advance request; one-cycle pulse (debounced key).
REQ-004 player_score  input  4  current player hand score 0-9 from datapath.
REQ-005 dealer_score  input  4  current dealer hand score 0-9 from datapath.
REQ-006 player_card3  input  4  player third-card rank; 0 = none, 1-13 = A..K.
REQ-007 deal_player_card  output  3  one-hot load strobe for player card slot 0/1/2.
REQ-008 deal_dealer_card  output  3  one-hot load strobe for dealer card slot 0/1/2.
REQ-009 player_win  output  1  player hand won, or tie.
REQ-010 dealer_win  output  1  dealer hand won, or tie.
REQ-011 busy  output  1  step currently ignored (settle window).
REQ-012 done  output  1  hand finished; result valid.

Function
REQ-013 States: DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, EVAL, BANKER, DONE.
REQ-014 Accepted step (step=1, busy=0, not DONE) in DEAL_P1/D1/P2/D2 deals player slot 0, dealer slot 0, player slot 1, dealer slot 1 respectively, then advances to the next state.
REQ-015 All deal strobes are registered: high for exactly one cycle, in the cycle after the accepting edge; at most one strobe bit high at any time.
REQ-016 busy asserts for the 2 cycles after any accepted step; steps arriving while busy=1 are dropped, not queued.
REQ-017 EVAL on accepted step: natural if either score is 8 or 9 -> DONE, no deal; else player_score <= 5 -> deal player slot 2, go to BANKER; else (player stands) dealer_score <= 5 -> deal dealer slot 2, go to DONE; else -> DONE.
REQ-018 BANKER on accepted step: t = rank value (rank >= 10 -> 0, else rank); dealer draws if dealer_score is 0-2; is 3 and t != 8; is 4 and t in 2-7; is 5 and t in 4-7; is 6 and t in 6-7; never at 7. Draw -> deal dealer slot 2, then DONE; no draw -> DONE.
REQ-019 Result is computed when DONE is reached and its final card has settled, i.e. 2 cycles after the entering step: player_win = player_score >= dealer_score; dealer_win = dealer_score >= player_score; both registered.
REQ-020 done rises with the registered result, never before it; in DONE steps are ignored and outputs hold until rst.
REQ-021 rst concurrent with step: reset wins; the step is discarded.

Reset
REQ-022 On rst: state DEAL_P1; all strobes 0; player_win, dealer_win, done, busy 0; settle counter 0.
REQ-023 rst mid-hand aborts without emitting any further strobe; the next accepted step deals player slot 0.

Structure
REQ-024 Package baccarat_pkg holds the state enum, RANK_NONE=0, NATURAL_MIN=8, DRAW_MAX=5.
REQ-025 Combinational sub-module banker_draw (inputs dealer_score and third-card rank; output draw) implements REQ-018.
REQ-026 Settle window is a 2-bit down-counter in this block; no other timing source.

Verification
REQ-027 rst, then 4 steps spaced 4 cycles apart -> strobes P=001, D=001, P=010, D=010, one cycle each; busy high 2 cycles after each step.
REQ-028 After deal, player=8, dealer=3, step -> no strobe; after 2 cycles done=1, player_win=1, dealer_win=0.
REQ-029 Player=4, dealer=3, step -> P=100; then player_card3=12 (Q, t=0); step -> D=100; final scores 5 vs 6 -> player_win=0, dealer_win=1.
REQ-030 Player=6, dealer=5, step -> D=100 directly, then DONE; final 6/6 -> player_win=1, dealer_win=1.
REQ-031 Player=2, dealer=6, step -> P=100; player_card3=8; step -> no strobe, DONE.
REQ-032 Step 1 cycle after an accepted step -> dropped, no strobe; rst during busy after DEAL_D1 strobe -> all outputs 0; next step -> P=001.

Source files
------------

// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat hand sequencer.
// Holds the FSM state encoding plus the scoring thresholds used by the controller and banker rule.
package baccarat_pkg;

    typedef enum logic [2:0] {
        DEAL_P1 = 3'd0,
        DEAL_D1 = 3'd1,
        DEAL_P2 = 3'd2,
        DEAL_D2 = 3'd3,
        EVAL    = 3'd4,
        BANKER  = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [3:0] RANK_NONE     = 4'd0;
    localparam logic [3:0] NATURAL_MIN   = 4'd8;
    localparam logic [3:0] DRAW_MAX      = 4'd5;
    localparam logic [1:0] SETTLE_CYCLES = 2'd2;

    localparam logic [2:0] SLOT_0    = 3'b001;
    localparam logic [2:0] SLOT_1    = 3'b010;
    localparam logic [2:0] SLOT_2    = 3'b100;
    localparam logic [2:0] SLOT_NONE = 3'b000;

    // Baccarat point value of a rank: tens and face cards count zero.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        logic [3:0] value;
        if (rank == RANK_NONE) begin
            value = 4'd0;
        end else if (rank >= 4'd10) begin
            value = 4'd0;
        end else begin
            value = rank;
        end
        return value;
    endfunction

endpackage

// File: rtl/baccarat_sm_banker_draw.sv
// Banker third-card tableau: decides whether the dealer draws, given the
// dealer's two-card score and the rank of the player's third card.
module banker_draw
    import baccarat_pkg::*;
(
    input  logic [3:0] dealer_score,
    input  logic [3:0] rank,
    output logic       draw
);

    logic [3:0] third_value;

    // Tableau lookup keyed on dealer score, windowed on the player's third-card value.
    always_comb begin
        third_value = card_value(rank);
        draw        = 1'b0;
        case (dealer_score)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (third_value != 4'd8);
            4'd4:             draw = (third_value >= 4'd2) && (third_value <= 4'd7);
            4'd5:             draw = (third_value >= 4'd4) && (third_value <= 4'd7);
            4'd6:             draw = (third_value >= 4'd6) && (third_value <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_sm.sv
// Baccarat hand sequencer: paces card-load strobes to the datapath on each step,
// applies the player/banker drawing rules and registers the final result.
module baccarat_sm
    import baccarat_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic [3:0] player_score,
    input  logic [3:0] dealer_score,
    input  logic [3:0] player_card3,
    output logic [2:0] deal_player_card,
    output logic [2:0] deal_dealer_card,
    output logic       player_win,
    output logic       dealer_win,
    output logic       busy,
    output logic       done
);

    state_t     state_r;
    state_t     state_nxt;
    logic [1:0] settle_r;
    logic [1:0] settle_nxt;
    logic [2:0] player_strobe_nxt;
    logic [2:0] dealer_strobe_nxt;
    logic       accept_s;
    logic       natural_s;
    logic       banker_draw_s;
    logic       result_load_s;

    banker_draw u_banker_draw (
        .dealer_score (dealer_score),
        .rank         (player_card3),
        .draw         (banker_draw_s)
    );

    assign accept_s  = step && (settle_r == 2'd0) && (state_r != DONE);
    assign natural_s = (player_score >= NATURAL_MIN) || (dealer_score >= NATURAL_MIN);
    // The last card loaded one cycle after its strobe, so scores are final when the window has one cycle left.
    assign result_load_s = (state_r == DONE) && (settle_r == 2'd1) && !done;

    // Next-state and strobe selection for an accepted step.
    always_comb begin
        state_nxt         = state_r;
        player_strobe_nxt = SLOT_NONE;
        dealer_strobe_nxt = SLOT_NONE;
        if (accept_s) begin
            case (state_r)
                DEAL_P1: begin
                    player_strobe_nxt = SLOT_0;
                    state_nxt         = DEAL_D1;
                end
                DEAL_D1: begin
                    dealer_strobe_nxt = SLOT_0;
                    state_nxt         = DEAL_P2;
                end
                DEAL_P2: begin
                    player_strobe_nxt = SLOT_1;
                    state_nxt         = DEAL_D2;
                end
                DEAL_D2: begin
                    dealer_strobe_nxt = SLOT_1;
                    state_nxt         = EVAL;
                end
                EVAL: begin
                    if (natural_s) begin
                        state_nxt = DONE;
                    end else if (player_score <= DRAW_MAX) begin
                        player_strobe_nxt = SLOT_2;
                        state_nxt         = BANKER;
                    end else if (dealer_score <= DRAW_MAX) begin
                        dealer_strobe_nxt = SLOT_2;
                        state_nxt         = DONE;
                    end else begin
                        state_nxt = DONE;
                    end
                end
                BANKER: begin
                    if (banker_draw_s) begin
                        dealer_strobe_nxt = SLOT_2;
                    end else begin
                        dealer_strobe_nxt = SLOT_NONE;
                    end
                    state_nxt = DONE;
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = DEAL_P1;
                end
            endcase
        end else begin
            state_nxt = state_r;
        end
    end

    // Settle window: reloads on every accepted step, then counts down to idle.
    always_comb begin
        settle_nxt = 2'd0;
        if (accept_s) begin
            settle_nxt = SETTLE_CYCLES;
        end else if (settle_r != 2'd0) begin
            settle_nxt = settle_r - 2'd1;
        end else begin
            settle_nxt = 2'd0;
        end
    end

    // State, settle counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= DEAL_P1;
            settle_r         <= 2'd0;
            busy             <= 1'b0;
            deal_player_card <= SLOT_NONE;
            deal_dealer_card <= SLOT_NONE;
            player_win       <= 1'b0;
            dealer_win       <= 1'b0;
            done             <= 1'b0;
        end else begin
            state_r          <= state_nxt;
            settle_r         <= settle_nxt;
            busy             <= (settle_nxt != 2'd0);
            deal_player_card <= player_strobe_nxt;
            deal_dealer_card <= dealer_strobe_nxt;
            if (result_load_s) begin
                player_win <= (player_score >= dealer_score);
                dealer_win <= (dealer_score >= player_score);
                done       <= 1'b1;
            end else begin
                player_win <= player_win;
                dealer_win <= dealer_win;
                done       <= done;
            end
        end
    end

endmodule

// File: tb/tb_baccarat_sm.sv
// Randomized bench for baccarat_sm: a hand-level reference model predicts every
// output cycle by cycle while scores, ranks, steps and resets are driven at random.
module tb_baccarat_sm;

    logic       clk = 1'b0;
    logic       rst;
    logic       step;
    logic [3:0] player_score;
    logic [3:0] dealer_score;
    logic [3:0] player_card3;
    logic [2:0] deal_player_card;
    logic [2:0] deal_dealer_card;
    logic       player_win;
    logic       dealer_win;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    baccarat_sm dut (
        .clk              (clk),
        .rst              (rst),
        .step             (step),
        .player_score     (player_score),
        .dealer_score     (dealer_score),
        .player_card3     (player_card3),
        .deal_player_card (deal_player_card),
        .deal_dealer_card (deal_dealer_card),
        .player_win       (player_win),
        .dealer_win       (dealer_win),
        .busy             (busy),
        .done             (done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: hand progress as counts and flags, banker tableau as bit masks.
    int         cards_dealt;
    bit         third_pending;
    bit         hand_over;
    int         cooldown;
    logic [2:0] m_p;
    logic [2:0] m_d;
    bit         m_busy, m_done, m_pw, m_dw;
    logic [9:0] draw_mask [10];

    task automatic model_edge(input bit r, input bit s, input int ps, input int ds, input int c3);
        bit accepted;
        int tv;
        m_p = 3'b000;
        m_d = 3'b000;
        if (r) begin
            cards_dealt = 0; third_pending = 0; hand_over = 0; cooldown = 0;
            m_busy = 0; m_done = 0; m_pw = 0; m_dw = 0;
        end else begin
            accepted = s && (cooldown == 0) && !hand_over;
            if (hand_over && cooldown == 1 && !m_done) begin
                m_pw = (ps >= ds);
                m_dw = (ds >= ps);
                m_done = 1;
            end
            if (accepted) begin
                if (cards_dealt < 4) begin
                    if (cards_dealt % 2 == 0) m_p = 3'(1 << (cards_dealt / 2));
                    else                      m_d = 3'(1 << (cards_dealt / 2));
                    cards_dealt++;
                end else if (!third_pending) begin
                    if (ps >= 8 || ds >= 8) hand_over = 1;
                    else if (ps <= 5) begin m_p = 3'b100; third_pending = 1; end
                    else if (ds <= 5) begin m_d = 3'b100; hand_over = 1; end
                    else hand_over = 1;
                end else begin
                    tv = (c3 >= 10) ? 0 : c3;
                    if (draw_mask[ds][tv]) m_d = 3'b100;
                    hand_over = 1;
                end
                cooldown = 2;
            end else if (cooldown > 0) begin
                cooldown--;
            end
            m_busy = (cooldown != 0);
        end
    endtask

    task automatic compare_all();
        check_val("deal_player_card", {5'd0, deal_player_card}, {5'd0, m_p});
        check_val("deal_dealer_card", {5'd0, deal_dealer_card}, {5'd0, m_d});
        check_val("busy",       {7'd0, busy},       {7'd0, m_busy});
        check_val("done",       {7'd0, done},       {7'd0, m_done});
        check_val("player_win", {7'd0, player_win}, {7'd0, m_pw});
        check_val("dealer_win", {7'd0, dealer_win}, {7'd0, m_dw});
    endtask

    initial begin
        bit r, s;
        int ps, ds, c3;
        for (int d = 0; d < 10; d++) draw_mask[d] = 10'h000;
        draw_mask[0] = 10'h3FF;
        draw_mask[1] = 10'h3FF;
        draw_mask[2] = 10'h3FF;
        draw_mask[3] = 10'h2FF;
        draw_mask[4] = 10'h0FC;
        draw_mask[5] = 10'h0F0;
        draw_mask[6] = 10'h0C0;

        rst = 1'b1; step = 1'b1;
        player_score = 4'd0; dealer_score = 4'd0; player_card3 = 4'd0;
        model_edge(1'b1, 1'b1, 0, 0, 0);

        for (int hand = 0; hand < 160; hand++) begin
            for (int cyc = 0; cyc < 50; cyc++) begin
                @(negedge clk);
                compare_all();
                r  = (cyc == 0) || ($urandom_range(0, 59) == 0);
                s  = ($urandom_range(0, 1) == 1);
                ps = $urandom_range(0, 9);
                ds = $urandom_range(0, 9);
                c3 = $urandom_range(0, 13);
                rst = r; step = s;
                player_score = 4'(ps); dealer_score = 4'(ds); player_card3 = 4'(c3);
                model_edge(r, s, ps, ds, c3);
            end
        end
        @(negedge clk);
        compare_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
